grf_mp: RTL and testbench
=========================

# grf_mp

Parametrised multi-port general register file with write-first bypass and a per-register pending-write scoreboard. It serves as the decode-stage register file of the pipelined core. It accepts two writeback ports per cycle (older and younger instruction) and supplies NRD combinational read ports to the decode/forwarding logic. The scoreboard gives the hazard unit a per-read-port "busy" flag for registers that have an issued but not yet written-back producer.

## Interface
- DW, 32, data width of each register
- AW, 5, address width; depth = 2**AW registers
- NRD, 3, number of read ports
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never marked busy
- clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- stall  input  1  when 1, all writes, scoreboard sets and scoreboard clears are suppressed this cycle
- wr0_en  input  1  write port 0 enable (older instruction)
- wr0_addr  input  AW  write port 0 address
- wr0_data  input  DW  write port 0 data
- wr1_en  input  1  write port 1 enable (younger instruction)
- wr1_addr  input  AW  write port 1 address
- wr1_data  input  DW  write port 1 data
- sb_set_en  input  1  mark sb_set_addr pending (producer issued)
- sb_set_addr  input  AW  register being claimed
- rd_addr  input  NRD*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data  output  NRD*DW  packed read data; port k at [k*DW +: DW]
- rd_busy  output  NRD  rd_busy[k] = pending bit of rd_addr port k
- busy_vec  output  2**AW  full scoreboard, for debug/flush logic

## Operation
- Storage: 2**AW x DW array plus a 2**AW-bit pending vector. Both are cleared asynchronously when Reset_n=0.
- Effective write: port p commits when wrp_en=1, stall=0 and Reset_n=1. With ZERO_REG=1, a commit to address 0 is dropped.
- Dual write to the same address: port 1 wins; port 0 data is discarded.
- Read port k, priority highest first:
  - ZERO_REG=1 and addr 0: returns 0.
  - Effective wr1 commit to the same address: returns wr1_data.
  - Effective wr0 commit to the same address: returns wr0_data.
  - Otherwise: returns the array contents.
- Scoreboard clear: each effective write clears the pending bit of its address at the clock edge.
- Scoreboard set: sb_set_en=1, stall=0 sets the pending bit of sb_set_addr at the clock edge. With ZERO_REG=1, setting address 0 is ignored.
- Set and clear of the same address in the same cycle: the set wins, because the new producer supersedes the old.
- rd_busy[k]: the pending bit of rd_addr k, masked to 0 in two cases:
  - an effective write to that address occurs this cycle (bypass covers it);
  - ZERO_REG=1 and the address is 0.
- busy_vec is the raw registered pending vector with no bypass masking.

## Timing
- Reads: purely combinational, 0-cycle latency. A write is visible the same cycle via bypass and from the array after the next rising edge.
- Scoreboard: a set is visible on rd_busy/busy_vec the cycle after the edge. A clear is visible on rd_busy in the same cycle (masking) and on busy_vec after the edge.
- Reset:
  - Reset_n low immediately forces the array, busy_vec and rd_busy to 0, regardless of clk.
  - While Reset_n is low, bypass is suppressed, so every rd_data is 0.
  - The first write is accepted on the first rising edge with Reset_n high.
  - Reset asserted mid-cycle discards any in-flight write.
- stall=1: state is frozen and reads still return array contents. Bypass is suppressed, because no commit happens.
- No handshake back-pressure: every effective write and set completes in one cycle.

## Test plan
- Reset then read: pulse Reset_n low between edges -> all rd_data=0, busy_vec=0 immediately. Then write 0xDEADBEEF to r5 -> the next cycle, rd_data port 0 (addr 5) = 0xDEADBEEF.
- Bypass and dual-write priority:
  - Same cycle: wr0 r7=0x11111111 and wr1 r7=0x22222222, read r7 on all ports -> all ports = 0x22222222 that cycle, and the array holds 0x22222222 afterwards.
  - wr0 alone to r8=0xAB -> read r8 the same cycle = 0xAB.
- Zero register: wr1 r0=0xFFFFFFFF plus sb_set r0 -> rd r0 = 0, rd_busy = 0, busy_vec[0] = 0 in all cycles.
- Scoreboard lifecycle:
  - Set r9 -> busy_vec[9]=1 next cycle, and rd_busy=1 on a port reading r9.
  - Write r9 the following cycle -> rd_busy=0 in that cycle and busy_vec[9]=0 after the edge.
  - Set and write r9 in the same cycle -> busy_vec[9]=1 after the edge.
- Stall: with stall=1, write r3=0x5 and set r4 -> the read of r3 returns its old value, and busy_vec is unchanged after the edge. Deassert stall and repeat -> both take effect.
- Parameter sweep: DW=16, AW=3, NRD=4, ZERO_REG=0.
  - Write r0=0x1234 -> r0 reads 0x1234.
  - Fill all 8 registers with random data, then read all 4 ports with distinct addresses -> data matches the reference model.

Source files
------------

// File: rtl/grf_mp.sv
// grf_mp: multi-port register file with write-first bypass and a per-register
// pending-write scoreboard feeding the hazard unit.
module grf_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NRD = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              stall,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  output logic [2**AW-1:0]  busy_vec
);
  localparam int D = 2**AW;
  localparam bit ZR = ZERO_REG != 0;
  logic [DW-1:0] mem [D];
  logic [D-1:0] pend, pend_nxt;
  logic we0, we1, set;
  // Commits are gated by Reset_n so bypass is dead while reset is held.
  assign we0 = wr0_en && !stall && Reset_n && !(ZR && wr0_addr == '0);
  assign we1 = wr1_en && !stall && Reset_n && !(ZR && wr1_addr == '0);
  assign set = sb_set_en && !stall && !(ZR && sb_set_addr == '0);
  assign busy_vec = pend;
  // Set is applied last: a newly issued producer supersedes the retiring one.
  always_comb begin
    pend_nxt = pend;
    if (we0) pend_nxt[wr0_addr] = 1'b0;
    if (we1) pend_nxt[wr1_addr] = 1'b0;
    if (set) pend_nxt[sb_set_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (we0) mem[wr0_addr] <= wr0_data;
      if (we1) mem[wr1_addr] <= wr1_data;
      pend <= pend_nxt;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic zr, h0, h1;
    assign a  = rd_addr[k*AW +: AW];
    assign zr = ZR && a == '0;
    assign h1 = we1 && wr1_addr == a;
    assign h0 = we0 && wr0_addr == a;
    assign rd_data[k*DW +: DW] = zr ? '0 : h1 ? wr1_data : h0 ? wr0_data : mem[a];
    assign rd_busy[k] = pend[a] && !h0 && !h1 && !zr;
  end
endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: scoreboard bench for grf_mp, default build plus a small
// DW=16/AW=3/NRD=4/ZERO_REG=0 build.
module tb_grf_mp;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_stall, a_w0e, a_w1e, a_se;
  logic [4:0] a_w0a, a_w1a, a_sa;
  logic [31:0] a_w0d, a_w1d, a_bv;
  logic [14:0] a_ra;
  logic [95:0] a_rd;
  logic [2:0] a_rb;
  logic b_stall, b_w0e, b_w1e, b_se;
  logic [2:0] b_w0a, b_w1a, b_sa;
  logic [15:0] b_w0d, b_w1d;
  logic [11:0] b_ra;
  logic [63:0] b_rd;
  logic [3:0] b_rb;
  logic [7:0] b_bv;
  grf_mp dut_a (
    .clk(clk), .Reset_n(rst_n), .stall(a_stall),
    .wr0_en(a_w0e), .wr0_addr(a_w0a), .wr0_data(a_w0d),
    .wr1_en(a_w1e), .wr1_addr(a_w1a), .wr1_data(a_w1d),
    .sb_set_en(a_se), .sb_set_addr(a_sa), .rd_addr(a_ra),
    .rd_data(a_rd), .rd_busy(a_rb), .busy_vec(a_bv)
  );
  grf_mp #(.DW(16), .AW(3), .NRD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .Reset_n(rst_n), .stall(b_stall),
    .wr0_en(b_w0e), .wr0_addr(b_w0a), .wr0_data(b_w0d),
    .wr1_en(b_w1e), .wr1_addr(b_w1a), .wr1_data(b_w1d),
    .sb_set_en(b_se), .sb_set_addr(b_sa), .rd_addr(b_ra),
    .rd_data(b_rd), .rd_busy(b_rb), .busy_vec(b_bv)
  );
  typedef struct {
    string tag;
    int sel;
    logic [63:0] val;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  // sel 0..2: A read ports, 3: A rd_busy, 4: A busy_vec; 10..13: B ports, 14/15: B busy
  function automatic logic [63:0] obs(input int s);
    case (s)
      0, 1, 2: return 64'(a_rd[s*32 +: 32]);
      3: return 64'(a_rb);
      4: return 64'(a_bv);
      10, 11, 12, 13: return 64'(b_rd[(s-10)*16 +: 16]);
      14: return 64'(b_rb);
      15: return 64'(b_bv);
      default: return 'x;
    endcase
  endfunction
  task automatic push(input int sel, input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask
  task automatic look;
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic a_idle;
    a_stall = 0; a_w0e = 0; a_w1e = 0; a_se = 0;
    a_w0a = 0; a_w1a = 0; a_sa = 0; a_w0d = 0; a_w1d = 0;
  endtask
  task automatic b_idle;
    b_stall = 0; b_w0e = 0; b_w1e = 0; b_se = 0;
    b_w0a = 0; b_w1a = 0; b_sa = 0; b_w0d = 0; b_w1d = 0;
  endtask
  task automatic a_rdset(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z);
    a_ra = {z, y, x};
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] mb [8];
    logic [7:0] bp;
    logic [3:0] rb;
    logic [2:0] ad;
    bit h0, h1;
    a_idle; b_idle;
    a_rdset(5, 6, 0);
    b_ra = '0;
    tick; tick;
    push(0, "rst_held_rd", 0); push(4, "rst_held_bv", 0);
    look;
    rst_n = 1;
    tick;
    a_w0e = 1; a_w0a = 5; a_w0d = 32'h0BADF00D; a_se = 1; a_sa = 6;
    push(0, "byp_wr0", 32'h0BADF00D); push(3, "set_not_yet", 0); push(4, "bv_pre_set", 0);
    look;
    tick;
    a_idle;
    push(0, "arr_r5", 32'h0BADF00D); push(4, "bv_r6", 32'h40); push(3, "busy_r6", 3'b010);
    look;
    rst_n = 0;
    a_w1e = 1; a_w1a = 5; a_w1d = 32'h12345678;
    push(0, "async_rst_rd", 0); push(4, "async_rst_bv", 0); push(3, "async_rst_busy", 0);
    look;
    rst_n = 1;
    a_idle;
    a_w0e = 1; a_w0a = 5; a_w0d = 32'hDEADBEEF;
    tick;
    a_idle;
    push(0, "post_rst_wr", 32'hDEADBEEF);
    look;
    tick;
    a_w0e = 1; a_w0a = 7; a_w0d = 32'h11111111;
    a_w1e = 1; a_w1a = 7; a_w1d = 32'h22222222;
    a_rdset(7, 7, 7);
    push(0, "dual_p0", 32'h22222222); push(1, "dual_p1", 32'h22222222); push(2, "dual_p2", 32'h22222222);
    look;
    tick;
    a_idle;
    a_w0e = 1; a_w0a = 8; a_w0d = 32'hAB;
    a_rdset(7, 8, 0);
    push(0, "dual_arr", 32'h22222222); push(1, "byp_r8", 32'hAB); push(2, "zero_p2", 0);
    look;
    tick;
    a_idle;
    a_w1e = 1; a_w1a = 0; a_w1d = 32'hFFFFFFFF; a_se = 1; a_sa = 0;
    a_rdset(0, 0, 0);
    push(0, "zr_byp", 0); push(3, "zr_busy", 0); push(4, "zr_bv", 0);
    look;
    tick;
    a_idle;
    a_rdset(0, 8, 0);
    push(0, "zr_arr", 0); push(1, "arr_r8", 32'hAB); push(4, "zr_bv2", 0); push(3, "zr_busy2", 0);
    look;
    tick;
    a_se = 1; a_sa = 9;
    a_rdset(9, 9, 9);
    push(3, "sb_set_busy0", 0); push(4, "sb_set_bv0", 0);
    look;
    tick;
    a_idle;
    a_rdset(0, 9, 0);
    push(4, "sb_bv9", 32'h200); push(3, "sb_busy9", 3'b010);
    look;
    tick;
    a_w0e = 1; a_w0a = 9; a_w0d = 32'h99;
    a_rdset(0, 9, 9);
    push(3, "clr_mask", 0); push(4, "clr_bv_hold", 32'h200); push(1, "clr_byp", 32'h99);
    look;
    tick;
    a_idle;
    push(4, "clr_bv", 0); push(3, "clr_busy", 0); push(2, "clr_arr", 32'h99);
    look;
    tick;
    a_se = 1; a_sa = 9; a_w1e = 1; a_w1a = 9; a_w1d = 32'h77;
    a_rdset(9, 0, 0);
    push(3, "setclr_mask", 0); push(0, "setclr_byp", 32'h77); push(4, "setclr_bv0", 0);
    look;
    tick;
    a_idle;
    a_rdset(9, 9, 0);
    push(4, "setclr_bv", 32'h200); push(3, "setclr_busy", 3'b011); push(0, "setclr_arr", 32'h77);
    look;
    tick;
    a_w0e = 1; a_w0a = 3; a_w0d = 32'hA;
    tick;
    a_idle;
    a_stall = 1; a_w0e = 1; a_w0a = 3; a_w0d = 32'h5; a_se = 1; a_sa = 4;
    a_rdset(3, 4, 9);
    push(0, "stall_rd", 32'hA); push(3, "stall_busy", 3'b100); push(4, "stall_bv", 32'h200);
    look;
    tick;
    a_stall = 0;
    push(0, "unstall_byp", 32'h5); push(4, "stall_bv_frozen", 32'h200); push(3, "unstall_busy", 3'b100);
    look;
    tick;
    a_idle;
    push(0, "unstall_arr", 32'h5); push(4, "unstall_bv", 32'h210); push(3, "unstall_busy2", 3'b110);
    look;
    for (int i = 0; i < 8; i++) mb[i] = '0;
    bp = '0;
    tick;
    b_w0e = 1; b_w0a = 0; b_w0d = 16'h1234; b_se = 1; b_sa = 0;
    b_ra = {3'd3, 3'd2, 3'd1, 3'd0};
    push(10, "b_r0_byp", 16'h1234); push(14, "b_busy0", 0); push(15, "b_bv0", 0);
    look;
    mb[0] = 16'h1234; bp = 8'h01;
    tick;
    b_idle;
    push(10, "b_r0_arr", 16'h1234); push(15, "b_bv_r0", 8'h01); push(14, "b_busy_r0", 4'b0001);
    look;
    for (int i = 0; i < 4; i++) begin
      tick;
      b_w0e = 1; b_w0a = 3'(2*i); b_w0d = 16'($urandom);
      b_w1e = 1; b_w1a = 3'(2*i+1); b_w1d = 16'($urandom);
      mb[b_w0a] = b_w0d; mb[b_w1a] = b_w1d;
      bp[b_w0a] = 1'b0; bp[b_w1a] = 1'b0;
    end
    tick;
    b_idle;
    b_ra = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 4; k++) push(10 + k, "b_fill_lo", mb[k]);
    push(15, "b_fill_bv", bp);
    look;
    tick;
    b_ra = {3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 4; k++) push(10 + k, "b_fill_hi", mb[7-k]);
    look;
    for (int c = 0; c < 40; c++) begin
      tick;
      b_stall = $urandom_range(0, 4) == 0;
      b_w0e = 1'($urandom); b_w0a = 3'($urandom); b_w0d = 16'($urandom);
      b_w1e = 1'($urandom); b_w1a = 3'($urandom); b_w1d = 16'($urandom);
      b_se = 1'($urandom); b_sa = 3'($urandom);
      b_ra = 12'($urandom);
      rb = '0;
      for (int k = 0; k < 4; k++) begin
        ad = b_ra[k*3 +: 3];
        h1 = !b_stall && b_w1e && b_w1a == ad;
        h0 = !b_stall && b_w0e && b_w0a == ad;
        push(10 + k, "b_rnd_rd", h1 ? b_w1d : h0 ? b_w0d : mb[ad]);
        rb[k] = bp[ad] && !h0 && !h1;
      end
      push(14, "b_rnd_busy", rb); push(15, "b_rnd_bv", bp);
      look;
      if (!b_stall) begin
        if (b_w0e) begin mb[b_w0a] = b_w0d; bp[b_w0a] = 1'b0; end
        if (b_w1e) begin mb[b_w1a] = b_w1d; bp[b_w1a] = 1'b0; end
        if (b_se) bp[b_sa] = 1'b1;
      end
    end
    tick;
    b_idle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
